// File: rtl/hit_detector.sv
// hit_detector: collects per-pixel sprite overlaps during a frame and resolves
// player collision and boss damage once per frame for the game-state FSM.
module hit_detector #(
    parameter int HP_W     = 8,
    parameter int BOSS_HP  = 200,
    parameter int HIT_DMG  = 1,
    parameter int BOMB_DMG = 20
) (
    input  logic            clk,
    input  logic            hard_reset_n,
    input  logic            game_en,
    input  logic            game_reset,
    input  logic [3:0]      game_state,
    input  logic            frame_end,
    input  logic            pix_valid,
    input  logic            player_px,
    input  logic            enemy_bullet_px,
    input  logic            player_bullet_px,
    input  logic            boss_px,
    output logic            collision,
    output logic            die,
    output logic            boss_hit,
    output logic [HP_W-1:0] boss_hp
);

    localparam logic [3:0]      GS_PLAY    = 4'b0010;
    localparam logic [3:0]      GS_BOMB    = 4'b0110;
    localparam logic [HP_W-1:0] HP_INIT    = HP_W'(BOSS_HP);
    localparam logic [HP_W:0]   HIT_DMG_W  = (HP_W + 1)'(HIT_DMG);
    localparam logic [HP_W:0]   BOMB_DMG_W = (HP_W + 1)'(BOMB_DMG);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_EVAL  = 2'd2,
        S_DEAD  = 2'd3
    } state_t;

    // Health floors at zero instead of wrapping when damage exceeds it.
    function automatic logic [HP_W-1:0] sat_sub(input logic [HP_W-1:0] hp,
                                                input logic [HP_W:0]   dmg);
        logic [HP_W-1:0] res;
        if (dmg >= {1'b0, hp}) res = '0;
        else                   res = hp - dmg[HP_W-1:0];
        return res;
    endfunction

    function automatic logic [HP_W:0] frame_dmg(input logic hit, input logic bomb);
        logic [HP_W:0] d_hit;
        logic [HP_W:0] d_bomb;
        d_hit  = hit  ? HIT_DMG_W  : '0;
        d_bomb = bomb ? BOMB_DMG_W : '0;
        return d_hit + d_bomb;
    endfunction

    state_t          state_q, state_d;
    logic            p_hit_q, p_hit_d;
    logic            b_hit_q, b_hit_d;
    logic            bomb_pend_q, bomb_pend_d;
    logic            die_q, die_d;
    logic [HP_W-1:0] hp_q, hp_d;
    logic [3:0]      prev_state_q;

    logic            pix_p_hit;
    logic            pix_b_hit;
    logic            bomb_edge;
    logic [HP_W:0]   dmg;
    logic [HP_W-1:0] hp_eval;

    assign pix_p_hit = pix_valid & player_px & (enemy_bullet_px | boss_px);
    assign pix_b_hit = pix_valid & player_bullet_px & boss_px;
    assign bomb_edge = (game_state == GS_BOMB) && (prev_state_q != GS_BOMB);
    assign dmg       = frame_dmg(b_hit_q, bomb_pend_q);
    assign hp_eval   = sat_sub(hp_q, dmg);

    always_comb begin
        state_d     = state_q;
        p_hit_d     = p_hit_q;
        b_hit_d     = b_hit_q;
        bomb_pend_d = bomb_pend_q | (bomb_edge && (state_q != S_DEAD));
        hp_d        = hp_q;
        die_d       = die_q;
        collision   = 1'b0;
        boss_hit    = 1'b0;

        if (game_reset) begin
            state_d     = S_IDLE;
            p_hit_d     = 1'b0;
            b_hit_d     = 1'b0;
            bomb_pend_d = 1'b0;
            hp_d        = HP_INIT;
            die_d       = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    p_hit_d = 1'b0;
                    b_hit_d = 1'b0;
                    if (game_en) state_d = S_ACCUM;
                end
                S_ACCUM: begin
                    if (!game_en) begin
                        state_d = S_IDLE;
                        p_hit_d = 1'b0;
                        b_hit_d = 1'b0;
                    end else begin
                        // The pixel in the frame_end cycle still belongs to this frame.
                        p_hit_d = p_hit_q | pix_p_hit;
                        b_hit_d = b_hit_q | pix_b_hit;
                        if (frame_end) state_d = S_EVAL;
                    end
                end
                S_EVAL: begin
                    hp_d        = hp_eval;
                    p_hit_d     = 1'b0;
                    b_hit_d     = 1'b0;
                    bomb_pend_d = bomb_edge;
                    boss_hit    = (dmg != '0) && (hp_q != '0);
                    if (hp_eval == '0) begin
                        die_d       = 1'b1;
                        bomb_pend_d = 1'b0;
                        state_d     = S_DEAD;
                    end else begin
                        // Bomb and Collision states make the player invulnerable.
                        collision = p_hit_q && (game_state == GS_PLAY);
                        state_d   = game_en ? S_ACCUM : S_IDLE;
                    end
                end
                S_DEAD: begin
                    p_hit_d     = 1'b0;
                    b_hit_d     = 1'b0;
                    bomb_pend_d = 1'b0;
                    die_d       = 1'b1;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge hard_reset_n) begin
        if (!hard_reset_n) begin
            state_q      <= S_IDLE;
            p_hit_q      <= 1'b0;
            b_hit_q      <= 1'b0;
            bomb_pend_q  <= 1'b0;
            hp_q         <= HP_INIT;
            die_q        <= 1'b0;
            prev_state_q <= '0;
        end else begin
            state_q      <= state_d;
            p_hit_q      <= p_hit_d;
            b_hit_q      <= b_hit_d;
            bomb_pend_q  <= bomb_pend_d;
            hp_q         <= hp_d;
            die_q        <= die_d;
            prev_state_q <= game_state;
        end
    end

    assign die     = die_q;
    assign boss_hp = hp_q;

endmodule

// File: tb/tb_hit_detector.sv
// Bench for hit_detector: two instances (BOSS_HP 200 and 15) share stimulus and
// are compared frame by frame against a frame-level model of the game rules.
module tb_hit_detector;

    localparam int HP_W = 8;
    localparam logic [3:0] PLAY = 4'b0010;
    localparam logic [3:0] BOMB = 4'b0110;
    localparam logic [3:0] COLL = 4'b1010;

    logic            clk = 1'b0;
    logic            hard_reset_n, game_en, game_reset;
    logic [3:0]      game_state;
    logic            frame_end, pix_valid, player_px, enemy_bullet_px;
    logic            player_bullet_px, boss_px;
    logic            col   [2];
    logic            die_o [2];
    logic            hit   [2];
    logic [HP_W-1:0] hp_o  [2];

    int   n_cmp  = 0;
    int   n_fail = 0;
    int   hp_m   [2];
    bit   dead_m [2];
    bit   pend_m [2];
    logic [3:0] prev_gs;

    always #5 clk = ~clk;

    hit_detector #(.HP_W(HP_W), .BOSS_HP(200), .HIT_DMG(1), .BOMB_DMG(20)) dut (
        .clk(clk), .hard_reset_n(hard_reset_n), .game_en(game_en), .game_reset(game_reset),
        .game_state(game_state), .frame_end(frame_end), .pix_valid(pix_valid),
        .player_px(player_px), .enemy_bullet_px(enemy_bullet_px),
        .player_bullet_px(player_bullet_px), .boss_px(boss_px),
        .collision(col[0]), .die(die_o[0]), .boss_hit(hit[0]), .boss_hp(hp_o[0])
    );

    hit_detector #(.HP_W(HP_W), .BOSS_HP(15), .HIT_DMG(1), .BOMB_DMG(20)) dut15 (
        .clk(clk), .hard_reset_n(hard_reset_n), .game_en(game_en), .game_reset(game_reset),
        .game_state(game_state), .frame_end(frame_end), .pix_valid(pix_valid),
        .player_px(player_px), .enemy_bullet_px(enemy_bullet_px),
        .player_bullet_px(player_bullet_px), .boss_px(boss_px),
        .collision(col[1]), .die(die_o[1]), .boss_hit(hit[1]), .boss_hp(hp_o[1])
    );

    function automatic int init_hp(input int k);
        return (k == 0) ? 200 : 15;
    endfunction

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s dut%0d: observed %0d, expected %0d", tag, k, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            hp_m[k]   = init_hp(k);
            dead_m[k] = 1'b0;
            pend_m[k] = 1'b0;
        end
    endtask

    // A bomb activation is the first cycle spent in Bomb after any other state.
    task automatic set_gs(input logic [3:0] g);
        game_state = g;
        for (int k = 0; k < 2; k++)
            if (!dead_m[k] && g == BOMB && prev_gs != BOMB) pend_m[k] = 1'b1;
        prev_gs = g;
    endtask

    task automatic quiet_checks(input string tag);
        for (int k = 0; k < 2; k++) begin
            chk({tag, "_collision"}, k, 32'(col[k]), 32'd0);
            chk({tag, "_boss_hit"},  k, 32'(hit[k]), 32'd0);
        end
    endtask

    task automatic idle_cycle(input logic [3:0] g);
        set_gs(g);
        pix_valid = 1'b0;
        frame_end = 1'b0;
        #3;
        quiet_checks("idle");
        tick();
    endtask

    // One frame of npix pixel cycles followed by the evaluation cycle.
    // Overlap modes: 0 never, 1 random, 2 every pixel, 3 exactly one pixel.
    task automatic frame(input logic [3:0] gs_a, input logic [3:0] gs_b, input int npix,
                         input int pm, input int bm, input bit do_rst);
        bit ep = 1'b0;
        bit eb = 1'b0;
        bit ec, eh;
        int dmg;
        int nh [2];
        bit nd [2];
        int idx = $urandom_range(npix - 1, 0);
        for (int i = 0; i < npix; i++) begin
            set_gs((i < npix / 2) ? gs_a : gs_b);
            pix_valid        = 1'($urandom_range(1, 0));
            player_px        = 1'($urandom_range(1, 0));
            enemy_bullet_px  = 1'($urandom_range(1, 0));
            player_bullet_px = 1'($urandom_range(1, 0));
            boss_px          = 1'($urandom_range(1, 0));
            if (pm == 2 || (pm == 3 && i == idx)) begin
                pix_valid = 1'b1; player_px = 1'b1; enemy_bullet_px = 1'b1;
            end
            if (bm == 2 || (bm == 3 && i == idx)) begin
                pix_valid = 1'b1; player_bullet_px = 1'b1; boss_px = 1'b1;
            end
            if (pm == 0 || (pm == 3 && i != idx)) player_px = player_px & ~(enemy_bullet_px | boss_px);
            if (bm == 0 || (bm == 3 && i != idx)) player_bullet_px = player_bullet_px & ~boss_px;
            ep |= pix_valid & player_px & (enemy_bullet_px | boss_px);
            eb |= pix_valid & player_bullet_px & boss_px;
            frame_end = (i == npix - 1);
            #3;
            quiet_checks("accum");
            tick();
        end
        set_gs(gs_b);
        pix_valid        = 1'($urandom_range(1, 0));
        player_px        = 1'b1;
        enemy_bullet_px  = 1'b1;
        player_bullet_px = 1'b1;
        boss_px          = 1'b1;
        frame_end        = 1'($urandom_range(1, 0));
        game_reset       = do_rst;
        #3;
        for (int k = 0; k < 2; k++) begin
            if (do_rst) begin
                ec = 0; eh = 0; nh[k] = init_hp(k); nd[k] = 1'b0;
            end else if (dead_m[k]) begin
                ec = 0; eh = 0; nh[k] = 0; nd[k] = 1'b1;
            end else begin
                dmg   = (eb ? 1 : 0) + (pend_m[k] ? 20 : 0);
                eh    = (dmg != 0);
                nh[k] = (dmg >= hp_m[k]) ? 0 : hp_m[k] - dmg;
                nd[k] = (nh[k] == 0);
                ec    = !nd[k] && ep && (gs_b == PLAY);
            end
            chk("eval_collision", k, 32'(col[k]), 32'(ec));
            chk("eval_boss_hit",  k, 32'(hit[k]), 32'(eh));
        end
        tick();
        game_reset = 1'b0;
        frame_end  = 1'b0;
        pix_valid  = 1'b0;
        for (int k = 0; k < 2; k++) begin
            hp_m[k]   = nh[k];
            dead_m[k] = nd[k];
            pend_m[k] = 1'b0;
            chk("boss_hp", k, 32'(hp_o[k]), 32'(hp_m[k]));
            chk("die",     k, 32'(die_o[k]), 32'(dead_m[k]));
        end
        if (do_rst) idle_cycle(gs_b);
    endtask

    initial begin
        logic [3:0] gs_tab [3];
        gs_tab[0] = PLAY; gs_tab[1] = BOMB; gs_tab[2] = COLL;
        hard_reset_n = 1'b0; game_en = 1'b0; game_reset = 1'b0; game_state = 4'b0000;
        frame_end = 1'b0; pix_valid = 1'b0; player_px = 1'b0; enemy_bullet_px = 1'b0;
        player_bullet_px = 1'b0; boss_px = 1'b0;
        prev_gs = 4'b0000;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("rst_boss_hp",   k, 32'(hp_o[k]), 32'(init_hp(k)));
            chk("rst_die",       k, 32'(die_o[k]), 32'd0);
            chk("rst_collision", k, 32'(col[k]), 32'd0);
            chk("rst_boss_hit",  k, 32'(hit[k]), 32'd0);
        end
        hard_reset_n = 1'b1;
        game_en      = 1'b1;
        idle_cycle(PLAY);

        // quiet frames, then single-pixel player hits in Play and Collision
        repeat (3) frame(PLAY, PLAY, $urandom_range(40, 8), 0, 0, 1'b0);
        frame(PLAY, PLAY, $urandom_range(30, 6), 3, 0, 1'b0);
        frame(COLL, COLL, $urandom_range(30, 6), 3, 0, 1'b0);
        // bomb early in the frame, back to Play at frame end: dut15 dies, die wins
        frame(BOMB, PLAY, 20, 3, 0, 1'b0);
        // Bomb held for two frames: a single 20-point hit, player invulnerable
        frame(BOMB, BOMB, 16, 3, 0, 1'b0);
        frame(BOMB, BOMB, 16, 3, 0, 1'b0);
        repeat (4) frame(PLAY, PLAY, 50, 0, 2, 1'b0);
        repeat (6) frame(gs_tab[$urandom_range(2, 0)], gs_tab[$urandom_range(2, 0)],
                         $urandom_range(40, 8), $urandom_range(3, 0), $urandom_range(3, 0), 1'b0);
        // game_reset in an evaluation cycle that would otherwise collide
        frame(PLAY, PLAY, 20, 3, 1, 1'b1);
        frame(PLAY, PLAY, 30, 0, 2, 1'b0);
        frame(BOMB, BOMB, 20, 0, 0, 1'b0);

        // asynchronous reset in the middle of an accumulating frame
        for (int i = 0; i < 3; i++) begin
            set_gs(PLAY);
            pix_valid = 1'b1; player_px = 1'b1; enemy_bullet_px = 1'b1;
            player_bullet_px = 1'b1; boss_px = 1'b1; frame_end = 1'b0;
            tick();
        end
        #2;
        hard_reset_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("async_boss_hp",   k, 32'(hp_o[k]), 32'(init_hp(k)));
            chk("async_die",       k, 32'(die_o[k]), 32'd0);
            chk("async_collision", k, 32'(col[k]), 32'd0);
            chk("async_boss_hit",  k, 32'(hit[k]), 32'd0);
        end
        tick();
        tick();
        hard_reset_n = 1'b1;
        pix_valid = 1'b0;
        prev_gs = 4'b0000;
        model_reset();
        idle_cycle(PLAY);
        frame(PLAY, PLAY, 30, 3, 2, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/hit_detector.md
Name: hit_detector

Overview:
Frame-synchronous hit-detection and boss-health block for the STG game.
- Watches per-pixel sprite overlap flags from the renderer during each frame.
- At frame end, resolves player damage and boss damage, and drives the `collision` and `die` event inputs of the game-state FSM.
- Consumes the FSM's `game_en`, `game_reset` and `game_state` outputs, so it closes the loop between renderer and game controller.

Parameters:
- HP_W, 8, width of boss health counter
- BOSS_HP, 200, boss health loaded on reset/game_reset (must fit HP_W)
- HIT_DMG, 1, boss damage per frame with any player-bullet/boss overlap
- BOMB_DMG, 20, boss damage applied once per bomb activation

Ports:
- clk  in  1  system clock
- hard_reset_n  in  1  asynchronous active-low reset
- game_en  in  1  game running enable from game FSM
- game_reset  in  1  synchronous one-cycle restart pulse from game FSM
- game_state  in  4  game FSM state code (Play=0010, Bomb=0110, Collision=1010)
- frame_end  in  1  one-cycle pulse at start of vertical blanking
- pix_valid  in  1  current pixel is in the active display area
- player_px  in  1  player sprite opaque at current pixel
- enemy_bullet_px  in  1  enemy bullet opaque at current pixel
- player_bullet_px  in  1  player bullet opaque at current pixel
- boss_px  in  1  boss sprite opaque at current pixel
- collision  out  1  one-cycle pulse: player hit this frame
- die  out  1  level: boss defeated; held until game_reset
- boss_hit  out  1  one-cycle pulse: boss took damage this frame
- boss_hp  out  HP_W  current boss health

Behaviour:
- Reset (hard_reset_n=0, async):
  - state=IDLE, boss_hp=BOSS_HP, collision=0, die=0, boss_hit=0.
  - Internal flags cleared; prev_state register cleared to 0000.
- States: IDLE, ACCUM, EVAL, DEAD.
- IDLE: flags held clear; go to ACCUM when game_en=1.
- ACCUM: each cycle with pix_valid=1:
  - p_hit |= player_px & (enemy_bullet_px | boss_px).
  - b_hit |= player_bullet_px & boss_px.
  - On frame_end, go to EVAL. The pixel sampled in the frame_end cycle still counts toward the frame.
  - If game_en=0: go to IDLE, clear flags, keep boss_hp.
- Bomb latch:
  - bomb_pend is set in any state except DEAD when game_state==0110 and prev_state!=0110.
  - prev_state <= game_state every cycle.
- EVAL (exactly one cycle):
  - dmg = (b_hit ? HIT_DMG : 0) + (bomb_pend ? BOMB_DMG : 0), computed in HP_W+1 bits.
  - boss_hp <= (dmg >= boss_hp) ? 0 : boss_hp - dmg.
  - boss_hit = 1 for this cycle if dmg != 0 and boss_hp != 0.
  - If the new hp is 0: die <= 1, go to DEAD; no collision pulse in this cycle (die wins).
  - Otherwise collision = 1 for this cycle iff p_hit=1 and game_state==0010. In Bomb or Collision state, hits are dropped (invulnerable).
  - Clear p_hit, b_hit and bomb_pend, then go to ACCUM (or IDLE if game_en=0).
  - Pixels arriving in the EVAL cycle are discarded; a frame_end arriving in EVAL is ignored.
- Output timing: collision and boss_hit are combinational from EVAL, so they assert in the cycle after frame_end. boss_hp and die update on the clock edge that leaves EVAL.
- DEAD:
  - die=1 held; all pixel inputs, frame_end and bomb edges are ignored.
  - boss_hp stays 0.
  - Leave DEAD only via game_reset or hard_reset_n.
- game_reset (sync, highest priority after async reset), in any state:
  - boss_hp <= BOSS_HP, die <= 0, flags and bomb_pend cleared, state <= IDLE.
  - collision and boss_hit forced 0 in that cycle.
- boss_hp never wraps below 0.
- collision is never asserted two cycles in a row and at most once per frame.

Test Plan:
- Reset release, game_en=1, no overlaps, 3 frame_end pulses: collision=0, boss_hit=0, boss_hp=200, die=0 throughout.
- game_state=0010, one pixel with player_px=enemy_bullet_px=1, then frame_end at cycle T: collision=1 only at T+1; boss_hp unchanged.
- Same hit with game_state=1010, then again with 0110: collision stays 0 in both frames.
- player_bullet_px&boss_px overlap on 50 pixels in each of 4 frames: boss_hp 200→196, one boss_hit pulse per frame.
- game_state steps 0010→0110 and stays there for 2 frames: boss_hp drops by exactly 20, once. With BOSS_HP=15: boss_hp=0, die=1, and collision suppressed even though p_hit was set that frame.
- In DEAD, overlaps and frame_end produce no change. game_reset pulse: die=0, boss_hp=200, state IDLE. hard_reset_n low mid-ACCUM clears all outputs immediately (asynchronously).
